// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default address / data widths
//   state_e                 : arbiter FSM states (IDLE, GNT0, GNT1)
package bus_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave port between two masters
// (master 0: instruction fetch, master 1: CPU data).
//
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   m0Valid/m0Wr/m0Addr/m0DataM2S : master 0 request (inputs)
//   m0DataS2M/m0Ready          : master 0 response (outputs)
//   m1*                        : same set for master 1
//   sValid/sWr/sAddr/sDataM2S  : request toward the slave (outputs)
//   sDataS2M/sReady            : slave response (inputs)
//
// The grant is registered; once granted, the master's request and the slave's
// response are passed through combinationally so a zero-wait slave completes
// in the first grant cycle.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0Valid,
    input  logic              m0Wr,
    input  logic [ADDR_W-1:0] m0Addr,
    input  logic [DATA_W-1:0] m0DataM2S,
    output logic [DATA_W-1:0] m0DataS2M,
    output logic              m0Ready,

    input  logic              m1Valid,
    input  logic              m1Wr,
    input  logic [ADDR_W-1:0] m1Addr,
    input  logic [DATA_W-1:0] m1DataM2S,
    output logic [DATA_W-1:0] m1DataS2M,
    output logic              m1Ready,

    output logic              sValid,
    output logic              sWr,
    output logic [ADDR_W-1:0] sAddr,
    output logic [DATA_W-1:0] sDataM2S,
    input  logic [DATA_W-1:0] sDataS2M,
    input  logic              sReady
);

    state_e state;
    logic   last_gnt;   // master that completed most recently
    logic   gnt0;
    logic   gnt1;
    logic   s_fire;

    // Grant and pass-through. Gating with rst forces every output low in the
    // reset cycle itself, so an in-flight transfer is dropped immediately.
    always_comb begin
        gnt0     = !rst && (state == GNT0);
        gnt1     = !rst && (state == GNT1);

        sValid   = 1'b0;
        sWr      = 1'b0;
        sAddr    = '0;
        sDataM2S = '0;
        if (gnt0) begin
            sValid   = m0Valid;
            sWr      = m0Wr;
            sAddr    = m0Addr;
            sDataM2S = m0DataM2S;
        end else if (gnt1) begin
            sValid   = m1Valid;
            sWr      = m1Wr;
            sAddr    = m1Addr;
            sDataM2S = m1DataM2S;
        end

        // sReady only counts while a request is actually presented.
        s_fire    = sValid && sReady;

        m0Ready   = gnt0 && s_fire;
        m1Ready   = gnt1 && s_fire;
        m0DataS2M = gnt0 ? sDataS2M : '0;
        m1DataS2M = gnt1 ? sDataS2M : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;   // master 0 wins the first tie
        end else begin
            case (state)
                IDLE: begin
                    if (m0Valid && m1Valid) begin
                        state <= last_gnt ? GNT0 : GNT1;
                    end else if (m0Valid) begin
                        state <= GNT0;
                    end else if (m1Valid) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (!m0Valid) begin
                        // Request withdrawn before completion.
                        state <= IDLE;
                    end else if (s_fire) begin
                        last_gnt <= 1'b0;
                        if (m1Valid) begin
                            state <= GNT1;
                        end else if (m0Valid) begin
                            state <= GNT0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GNT1: begin
                    if (!m1Valid) begin
                        state <= IDLE;
                    end else if (s_fire) begin
                        last_gnt <= 1'b1;
                        if (m0Valid) begin
                            state <= GNT0;
                        end else if (m1Valid) begin
                            state <= GNT1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of all ports.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port m0Valid  input  1  master 0 (instruction fetch) request, held until m0Ready.
REQ-006 SHALL have port m0Wr  input  1  master 0 write (1) / read (0).
REQ-007 SHALL have port m0Addr  input  ADDR_W  master 0 address.
REQ-008 SHALL have port m0DataM2S  input  DATA_W  master 0 write data.
REQ-009 SHALL have port m0DataS2M  output  DATA_W  master 0 read data.
REQ-010 SHALL have port m0Ready  output  1  master 0 transfer complete.
REQ-011 SHALL have ports m1Valid, m1Wr, m1Addr, m1DataM2S, m1DataS2M, m1Ready, identical to REQ-005..010, for master 1 (CPU data).
REQ-012 SHALL have ports sValid, sWr, sAddr, sDataM2S (outputs) and sDataS2M, sReady (inputs), forming the shared slave port toward the data cache / peripheral bus.

Function
REQ-013 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-014 SHALL, in IDLE, drive sValid=0 and both mxReady=0.
REQ-015 SHALL, in IDLE with only mxValid=1, move to GNTx next cycle (one cycle of arbitration latency).
REQ-016 SHALL, in IDLE with both valid, grant the master not recorded in lastGnt (round-robin).
REQ-017 SHALL, in GNTx, pass mxValid/mxWr/mxAddr/mxDataM2S combinationally to the slave port.
REQ-018 SHALL, in GNTx, drive mxReady=sReady and mxDataS2M=sDataS2M in the same cycle.
REQ-019 SHALL drive the non-granted master's Ready=0 and DataS2M=0 at all times.
REQ-020 SHALL hold GNTx, with no preemption, until a cycle with sReady=1 and sValid=1.
REQ-021 SHALL, on completion in GNTx, set lastGnt=x and select the next state that cycle: GNT(other) if other valid, else GNTx if mxValid is reasserted (back-to-back), else IDLE.
REQ-022 SHALL NOT forward sReady to any master when sValid=0.
REQ-023 SHALL, if mxValid drops in GNTx before ready (protocol violation), return to IDLE next cycle without asserting any Ready.
REQ-024 SHALL provide a single-cycle transfer path: a zero-wait slave yields mxReady in the first GNTx cycle.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, enter IDLE and set lastGnt=1, so master 0 wins the first tie.
REQ-026 SHALL drive all outputs to 0 (sValid, sWr, sAddr, sDataM2S, mxReady, mxDataS2M) during reset.
REQ-027 SHALL abandon an in-flight grant on reset; the slave sees sValid=0 from the reset cycle onward.

Structure
REQ-028 SHALL take ADDR_W/DATA_W defaults and the state enum (IDLE, GNT0, GNT1) from shared package bus_pkg.
REQ-029 SHALL be one flat module; no sub-module (a 2:1 mux does not justify one).

Verification
REQ-030 Reset, then m0Valid=1, m0Addr=0x0000, slave zero-wait with sDataS2M=0xdeadbeef -> GNT0 next cycle; m0Ready=1, m0DataS2M=0xdeadbeef in that cycle; m1Ready=0.
REQ-031 Both valid in the same IDLE cycle after reset (m0Addr=0x0004, m1Addr=0x0008) -> m0 served first; m1 granted the cycle after m0Ready, no IDLE gap.
REQ-032 m1 write 0x7f00 / 0x123 with slave ready 3 cycles late; m0 requests mid-transfer -> sAddr stays 0x7f00 for all 3 cycles; m0 granted only after m1Ready.
REQ-033 Both masters request continuously for 6 transfers -> grants alternate 0,1,0,1,0,1.
REQ-034 rst asserted during GNT1 wait state -> next cycle sValid=0, m1Ready=0, state IDLE; a later tie grants m0.
REQ-035 m0Valid dropped in GNT0 before sReady -> IDLE next cycle; m0Ready never asserted.
